// File: rtl/mem_arbiter.sv
// Two-icache plus data-side arbiter for one memory port; one-cycle IDLE arbitration, grants held until the word completes.
// Stalls requesters via iwait/dwait while ramwait is high; a starved icache is inserted after a completed data word.
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [1:0]  iREN,
  input  logic [31:0] iaddr0,
  input  logic [31:0] iaddr1,
  output logic [1:0]  iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ramwait
);

  typedef enum logic [1:0] {IDLE, DGNT, I0GNT, I1GNT} state_t;

  localparam logic [3:0] STARVE_LIM = STARVE_MAX[3:0];

  state_t     state;
  logic       last_i;
  logic [3:0] starve;

  logic   d_req;
  logic   i_any;
  logic   starved;
  logic   i_pick;
  state_t i_next;
  logic   in_icache;
  logic   cur_core;
  logic   i_hold;
  logic   i_done;

  assign d_req     = dREN | dWEN;
  assign i_any     = |iREN;
  assign starved   = (starve >= STARVE_LIM);
  // Round-robin between the cores only matters when both are asking.
  assign i_pick    = (iREN == 2'b11) ? ~last_i : iREN[1];
  assign i_next    = i_pick ? I1GNT : I0GNT;
  assign in_icache = (state == I0GNT) || (state == I1GNT);
  assign cur_core  = (state == I1GNT);
  assign i_hold    = iREN[cur_core];
  assign i_done    = in_icache && i_hold && !ramwait;

  always_comb begin
    iwait    = 2'b11;
    iload    = '0;
    dwait    = 1'b1;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    unique case (state)
      DGNT: begin
        ramaddr = daddr;
        if (dWEN) begin
          ramWEN   = 1'b1;
          ramstore = dstore;
        end else begin
          ramREN = dREN;
        end
        if (d_req && !ramwait) begin
          dwait = 1'b0;
          if (!dWEN) dload = ramload;
        end
      end
      I0GNT, I1GNT: begin
        ramREN  = 1'b1;
        ramaddr = cur_core ? iaddr1 : iaddr0;
        if (i_done) begin
          iwait[cur_core] = 1'b0;
          iload           = ramload;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      last_i <= 1'b1;
      starve <= '0;
    end else begin
      if (i_done)
        starve <= '0;
      else if (state == DGNT && i_any && starve != 4'hF)
        starve <= starve + 4'd1;

      unique case (state)
        IDLE: begin
          if (i_any && starved)  state <= i_next;
          else if (d_req)        state <= DGNT;
          else if (i_any)        state <= i_next;
        end
        DGNT: begin
          if (!d_req)                           state <= IDLE;
          else if (!ramwait && starved && i_any) state <= i_next;
        end
        I0GNT, I1GNT: begin
          // A withdrawn fetch leaves without a response and keeps the fairness order.
          if (!i_hold) begin
            state <= IDLE;
          end else if (!ramwait) begin
            state  <= IDLE;
            last_i <= cur_core;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run against a cycle-level ownership model.
module tb_mem_arbiter;

  localparam int STARVE = 8;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [1:0]  iREN;
  logic [31:0] iaddr0, iaddr1;
  logic [1:0]  iwait;
  logic [31:0] iload;
  logic        dREN, dWEN;
  logic [31:0] daddr, dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore;
  logic [31:0] ramload;
  logic        ramwait;

  int checks = 0;
  int fails  = 0;

  mem_arbiter #(.STARVE_MAX(STARVE)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr0(iaddr0), .iaddr1(iaddr1), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramwait(ramwait)
  );

  always #5 CLK = ~CLK;

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  // Leaves the DUT in IDLE with inputs quiet, 1 time unit after a rising edge.
  task automatic do_reset();
    nRST = 1'b0;
    iREN = 2'b00; dREN = 1'b0; dWEN = 1'b0;
    iaddr0 = '0; iaddr1 = '0; daddr = '0; dstore = '0;
    ramload = '0; ramwait = 1'b1;
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    iREN = 2'b11; dREN = 1'b1; dWEN = 1'b1;
    iaddr0 = 32'h11; iaddr1 = 32'h22; daddr = 32'h33; dstore = 32'h44;
    ramload = 32'h55; ramwait = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (ramREN !== 1'b0 || ramWEN !== 1'b0 || iwait !== 2'b11 || dwait !== 1'b1) begin
      fails++;
      $display("FAIL reset_strobes: ramREN=%b ramWEN=%b iwait=%b dwait=%b, required 0 0 11 1",
               ramREN, ramWEN, iwait, dwait);
    end
    checks++;
    if (iload !== 0 || dload !== 0 || ramaddr !== 0 || ramstore !== 0) begin
      fails++;
      $display("FAIL reset_data: iload=%h dload=%h ramaddr=%h ramstore=%h, required all 0",
               iload, dload, ramaddr, ramstore);
    end
  endtask

  task automatic test_alternate();
    do_reset();
    iREN = 2'b11; iaddr0 = 32'h100; iaddr1 = 32'h200; ramwait = 1'b0;
    for (int i = 0; i < 8; i++) begin
      logic [31:0] ld;
      ld = $urandom;
      ramload = ld;
      @(negedge CLK);
      checks++;
      if (i % 2 == 0) begin
        if (ramREN !== 1'b0 || iwait !== 2'b11) begin
          fails++;
          $display("FAIL alternate_idle c%0d: ramREN=%b iwait=%b, required 0 11", i, ramREN, iwait);
        end
      end else begin
        int core;
        logic [31:0] ea;
        logic [1:0]  ew;
        core = (i / 2) % 2;
        ea = core ? 32'h200 : 32'h100;
        ew = core ? 2'b01 : 2'b10;
        if (ramREN !== 1'b1 || ramaddr !== ea || iwait !== ew || iload !== ld) begin
          fails++;
          $display("FAIL alternate_grant c%0d: ramREN=%b ramaddr=%h iwait=%b iload=%h, required 1 %h %b %h",
                   i, ramREN, ramaddr, iwait, iload, ea, ew, ld);
        end
      end
      next_cycle();
    end
    iREN = 2'b00;
  endtask

  task automatic test_data_priority();
    do_reset();
    dREN = 1'b1; iREN = 2'b01; daddr = 32'h80; iaddr0 = 32'h300; ramwait = 1'b0;
    ramload = 32'hA5A5_0001;
    for (int c = 0; c < 9; c++) begin
      if (c == 5) dREN = 1'b0;
      @(negedge CLK);
      checks++;
      if (c >= 1 && c <= 4) begin
        if (ramREN !== 1'b1 || ramaddr !== 32'h80 || dwait !== 1'b0 || iwait !== 2'b11 || dload !== 32'hA5A5_0001) begin
          fails++;
          $display("FAIL data_priority_dgnt c%0d: ramREN=%b ramaddr=%h dwait=%b iwait=%b dload=%h, required 1 80 0 11 a5a50001",
                   c, ramREN, ramaddr, dwait, iwait, dload);
        end
      end else if (c == 7) begin
        if (ramaddr !== 32'h300 || iwait !== 2'b10) begin
          fails++;
          $display("FAIL data_priority_icache c%0d: ramaddr=%h iwait=%b, required 300 10", c, ramaddr, iwait);
        end
      end else begin
        if (iwait !== 2'b11 || dwait !== 1'b1) begin
          fails++;
          $display("FAIL data_priority_quiet c%0d: iwait=%b dwait=%b, required 11 1", c, iwait, dwait);
        end
      end
      next_cycle();
    end
    iREN = 2'b00;
  endtask

  task automatic test_write_wait();
    do_reset();
    dWEN = 1'b1; daddr = 32'h40; dstore = 32'hDEAD_BEEF; ramwait = 1'b1; ramload = 32'h1234_5678;
    next_cycle();
    for (int c = 1; c <= 4; c++) begin
      ramwait = (c == 4) ? 1'b0 : 1'b1;
      @(negedge CLK);
      checks++;
      if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h40 || ramstore !== 32'hDEAD_BEEF ||
          dwait !== (c != 4) || dload !== 32'h0) begin
        fails++;
        $display("FAIL write_wait c%0d: ramWEN=%b ramREN=%b ramaddr=%h ramstore=%h dwait=%b dload=%h, required 1 0 40 deadbeef %b 0",
                 c, ramWEN, ramREN, ramaddr, ramstore, dwait, dload, (c != 4));
      end
      next_cycle();
    end
    dWEN = 1'b0;
  endtask

  task automatic test_starve();
    do_reset();
    dREN = 1'b1; iREN = 2'b10; daddr = 32'h700; iaddr1 = 32'h900; ramwait = 1'b0;
    // IDLE, 9 data words, inserted core-1 fetch, IDLE, then the same pattern again.
    for (int c = 0; c < 24; c++) begin
      logic [31:0] ld;
      ld = $urandom;
      ramload = ld;
      @(negedge CLK);
      checks++;
      if (c == 0 || c == 11 || c == 22) begin
        if (ramREN !== 1'b0 || iwait !== 2'b11 || dwait !== 1'b1) begin
          fails++;
          $display("FAIL starve_idle c%0d: ramREN=%b iwait=%b dwait=%b, required 0 11 1", c, ramREN, iwait, dwait);
        end
      end else if (c == 10 || c == 21) begin
        if (iwait !== 2'b01 || ramaddr !== 32'h900 || dwait !== 1'b1 || iload !== ld) begin
          fails++;
          $display("FAIL starve_insert c%0d: iwait=%b ramaddr=%h dwait=%b iload=%h, required 01 900 1 %h",
                   c, iwait, ramaddr, dwait, iload, ld);
        end
      end else begin
        if (dwait !== 1'b0 || iwait !== 2'b11 || ramaddr !== 32'h700 || dload !== ld) begin
          fails++;
          $display("FAIL starve_data c%0d: dwait=%b iwait=%b ramaddr=%h dload=%h, required 0 11 700 %h",
                   c, dwait, iwait, ramaddr, dload, ld);
        end
      end
      next_cycle();
    end
    dREN = 1'b0; iREN = 2'b00;
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    iREN = 2'b01; iaddr0 = 32'h500; iaddr1 = 32'h600; ramwait = 1'b1;
    next_cycle();
    @(negedge CLK);
    checks++;
    if (ramREN !== 1'b1 || ramaddr !== 32'h500) begin
      fails++;
      $display("FAIL midreset_grant: ramREN=%b ramaddr=%h, required 1 500", ramREN, ramaddr);
    end
    @(posedge CLK);
    #2 nRST = 1'b0;
    #1;
    checks++;
    if (ramREN !== 1'b0 || iwait !== 2'b11 || ramaddr !== 32'h0) begin
      fails++;
      $display("FAIL midreset_abort: ramREN=%b iwait=%b ramaddr=%h, required 0 11 0", ramREN, iwait, ramaddr);
    end
    iREN = 2'b11; ramwait = 1'b0;
    next_cycle();
    nRST = 1'b1;
    next_cycle();
    @(negedge CLK);
    checks++;
    if (ramaddr !== 32'h500 || iwait !== 2'b10) begin
      fails++;
      $display("FAIL midreset_first: ramaddr=%h iwait=%b, required 500 10", ramaddr, iwait);
    end
    next_cycle();
    iREN = 2'b00;
  endtask

  // Model: who owns the memory port (-1 nobody, 0/1 a core, 2 data side).
  task automatic test_random();
    int          owner, nxt, last_core, blocked, pick;
    logic        e_iw0, e_iw1, e_dw, e_ren, e_wen;
    logic [31:0] e_iload, e_dload, e_addr, e_store;
    logic        dreq;
    do_reset();
    owner = -1; last_core = 1; blocked = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7) == 0) {dWEN, dREN} = 2'($urandom_range(1, 3));
      if ($urandom_range(7) == 0) {dWEN, dREN} = 2'b00;
      if ($urandom_range(5) == 0) iREN[0] = ~iREN[0];
      if ($urandom_range(5) == 0) iREN[1] = ~iREN[1];
      iaddr0 = $urandom; iaddr1 = $urandom; daddr = $urandom; dstore = $urandom;
      ramload = $urandom; ramwait = ($urandom_range(2) == 0);
      @(negedge CLK);
      dreq = dREN | dWEN;
      e_iw0 = 1; e_iw1 = 1; e_dw = 1; e_ren = 0; e_wen = 0;
      e_iload = 0; e_dload = 0; e_addr = 0; e_store = 0;
      if (owner == 2) begin
        e_addr = daddr;
        if (dWEN) begin e_wen = 1; e_store = dstore; end
        else e_ren = dREN;
        if (dreq && !ramwait) begin e_dw = 0; e_dload = dWEN ? 32'h0 : ramload; end
      end else if (owner >= 0) begin
        e_ren = 1;
        e_addr = (owner == 1) ? iaddr1 : iaddr0;
        if (iREN[owner] && !ramwait) begin
          if (owner == 1) e_iw1 = 0; else e_iw0 = 0;
          e_iload = ramload;
        end
      end
      checks++;
      if (iwait !== {e_iw1, e_iw0} || dwait !== e_dw || ramREN !== e_ren || ramWEN !== e_wen ||
          iload !== e_iload || dload !== e_dload || ramaddr !== e_addr || ramstore !== e_store) begin
        fails++;
        $display("FAIL random c%0d owner=%0d: iwait=%b dwait=%b ren=%b wen=%b iload=%h dload=%h addr=%h store=%h, required %b%b %b %b %b %h %h %h %h",
                 c, owner, iwait, dwait, ramREN, ramWEN, iload, dload, ramaddr, ramstore,
                 e_iw1, e_iw0, e_dw, e_ren, e_wen, e_iload, e_dload, e_addr, e_store);
      end
      pick = (iREN == 2'b11) ? 1 - last_core : (iREN[1] ? 1 : 0);
      nxt = owner;
      if (owner == -1) begin
        if (iREN != 0 && blocked >= STARVE) nxt = pick;
        else if (dreq)                      nxt = 2;
        else if (iREN != 0)                 nxt = pick;
      end else if (owner == 2) begin
        if (!dreq) nxt = -1;
        else if (!ramwait && blocked >= STARVE && iREN != 0) nxt = pick;
        if (iREN != 0 && blocked < 15) blocked++;
      end else begin
        if (!iREN[owner]) nxt = -1;
        else if (!ramwait) begin nxt = -1; last_core = owner; blocked = 0; end
      end
      owner = nxt;
      next_cycle();
    end
    iREN = 2'b00; dREN = 1'b0; dWEN = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_data_priority();
    test_write_wait();
    test_starve();
    test_reset_mid_grant();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
